// File: rtl/sram_walker.sv
// sram_walker: internal synchronous-read SRAM, loaded through a write port
// while idle, then walked on `start` in one of two modes. In countdown mode
// the address decrements to 0. In linked mode each word's low AW bits point to
// the next word. Every visited word is streamed out over valid/ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data     SRAM write port, honoured only in IDLE (wins over start)
//   start, mode,        begin walk (mode 0 = countdown, 1 = linked) at
//   start_addr          start_addr; sampled only in IDLE
//   out_valid/ready     output handshake; out_data/out_addr hold while stalled
//   out_data, out_addr  visited word and the address it came from
//   busy                high while reading / presenting words
//   done                one-cycle pulse when a walk ends
//   err_loop            sticky: walk aborted after MAX_STEPS words
//   zero                address register is 0
module sram_walker #(
  parameter int DW        = 32,
  parameter int AW        = 9,
  parameter int MAX_STEPS = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] start_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err_loop,
  output logic          zero
);

  localparam int DEPTH = 2**AW;
  // The step counter is AW+1 bits wide so that a limit of 2**AW fits.
  localparam logic [AW:0] STEP_LIMIT = (AW+1)'(MAX_STEPS);

  typedef enum logic [1:0] {IDLE, RD, OUT, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_q;
  logic [AW-1:0] sram_addr;
  logic          mode_q;
  logic [AW:0]   step_q;
  logic [AW:0]   step_inc;
  logic          write_ok;
  logic          start_ok;
  logic          accept;
  logic          term_natural;
  logic          term_guard;

  assign write_ok = (state_q == IDLE) && wr_en;
  assign start_ok = (state_q == IDLE) && !wr_en && start;
  assign accept   = (state_q == OUT) && out_ready;
  assign step_inc = step_q + (AW+1)'(1);

  // Walk ends on address 0 in countdown mode, or on a null pointer in linked
  // mode. The loop guard applies only when neither condition holds.
  assign term_natural = mode_q ? (out_data[AW-1:0] == '0) : (out_addr == '0);
  assign term_guard   = (step_inc == STEP_LIMIT);

  // Single-port SRAM: the write address is selected only for an accepted write.
  assign sram_addr = write_ok ? wr_addr : addr_q;
  assign zero      = (addr_q == '0);

  // NOTE: the memory array has no reset. Its contents must survive rst, and a
  // reset would also prevent it from mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[sram_addr] <= wr_data;
    end
  end

  // State register
  // NOTE: sequential state is assigned with <= only. Every flop then samples
  // pre-edge values, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: a default is assigned before the case, so no path leaves state_d
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RD;
      RD:   state_d = OUT;
      OUT:  if (accept) state_d = (term_natural || term_guard) ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. The outputs are taken straight from the state register, so
  // an asynchronous reset clears them in the same cycle.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      RD:   busy = 1'b1;
      OUT:  begin busy = 1'b1; out_valid = 1'b1; end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address register, step count, output word and loop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      mode_q   <= 1'b0;
      step_q   <= '0;
      out_data <= '0;
      out_addr <= '0;
      err_loop <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q   <= start_addr;
        mode_q   <= mode;
        step_q   <= '0;
        err_loop <= 1'b0;
      end
      // The SRAM read lands directly in the output register when OUT is
      // entered. It then stays stable for the whole OUT stay.
      if (state_q == RD) begin
        out_data <= mem[sram_addr];
        out_addr <= addr_q;
      end
      if (accept) begin
        step_q <= step_inc;
        if (!term_natural) begin
          if (term_guard) begin
            err_loop <= 1'b1;
          end else begin
            addr_q <= mode_q ? out_data[AW-1:0] : (out_addr - AW'(1));
          end
        end
      end
    end
  end

endmodule

// File: doc/sram_walker.md
Name: sram_walker

Overview:
- Parametrised successor to the single-SRAM data fetcher.
- Owns an internal synchronous-read SRAM that is loaded through a write port while idle.
- On `start`, walks the SRAM in one of two modes:
  - countdown: address decrements to 0;
  - linked: each word's low AW bits are the next pointer.
- Streams each visited word out over a valid/ready handshake to the downstream adder datapath.
- Adds start/busy/done control, backpressure and a runaway-loop guard.

Parameters:
- DW, 32, data word width (must satisfy DW >= AW).
- AW, 9, address width; DEPTH = 2**AW words.
- MAX_STEPS, 2**AW, words emitted before loop abort (1..2**AW).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  SRAM write strobe, honoured only in IDLE
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- start  in  1  begin walk, sampled only in IDLE
- mode  in  1  0 = countdown, 1 = linked; captured at start
- start_addr  in  AW  first address visited; captured at start
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  downstream accepts word
- out_data  out  DW  SRAM word read
- out_addr  out  AW  address the word came from
- busy  out  1  high in RD/OUT
- done  out  1  one-cycle pulse at walk end
- err_loop  out  1  sticky, set when MAX_STEPS is hit; cleared by next accepted start or rst
- zero  out  1  current address register == 0

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - out_valid=0, out_data=0, out_addr=0, busy=0, done=0, err_loop=0.
  - address register=0, so zero=1.
  - SRAM array is not reset; contents are retained.
- SRAM: single port, 1-cycle read latency. The address mux selects wr_addr when writing in IDLE, otherwise the address register.
- FSM states:
  - IDLE:
    - wr_en=1 writes mem[wr_addr]=wr_data. wr_en has priority: a start in the same cycle is ignored.
    - start=1 with wr_en=0 captures mode and start_addr into the address register, clears err_loop and step count, and goes to RD.
  - RD: address presented to SRAM; go to OUT.
  - OUT:
    - Register out_data and out_addr on entry; out_valid=1.
    - Hold all outputs stable while out_ready=0.
    - On out_valid && out_ready, step count is incremented and termination is tested:
      - countdown: terminate if out_addr==0; else next addr = out_addr-1, go to RD;
      - linked: terminate if out_data[AW-1:0]==0 (null pointer); else next addr = that pointer, go to RD;
      - step count == MAX_STEPS without termination: set err_loop, terminate.
    - Terminate means go to DONE.
  - DONE: done=1 for one cycle, out_valid=0; go to IDLE.
- Linked mode: address 0 may only be the head (start_addr=0 allowed), because pointer 0 means end.
- Timing:
  - start sampled at edge T → RD during T+1 → out_valid from T+2.
  - Steady-state throughput is 1 word per 2 cycles with out_ready held high.
- Ignored inputs: start while busy is ignored. wr_en while not IDLE is ignored and memory is unchanged.
- Arithmetic:
  - countdown decrement never wraps, because 0 terminates.
  - Step counter is AW+1 bits wide, so MAX_STEPS=2**AW is representable.
- Mid-walk reset: abort immediately; no done pulse; outputs go to reset values.

Test Plan:
- Countdown:
  - Stimulus: mem[3..0]=0x33,0x22,0x11,0x00; start mode=0 start_addr=3; out_ready=1.
  - Response: words (3,0x33),(2,0x22),(1,0x11),(0,0x00) on cycles T+2,T+4,T+6,T+8; done pulse at T+9; err_loop=0.
- Linked:
  - Stimulus: mem[0]=5, mem[5]=2, mem[2]=0; start mode=1 start_addr=0.
  - Response: addresses 0,5,2 emitted in order; done after the word from address 2; zero=1 during the first RD.
- Backpressure:
  - Stimulus: countdown from 1; out_ready=0 for 4 cycles after the first out_valid.
  - Response: out_data/out_addr stable at (1,mem[1]) for all 4 cycles; no extra words; two words total.
- Loop guard:
  - Stimulus: AW=3, MAX_STEPS=8, mem[4]=4; start mode=1 start_addr=4.
  - Response: exactly 8 words from address 4; err_loop=1; done pulses once; a new start clears err_loop.
- Write/start priority:
  - Stimulus: wr_en and start in the same IDLE cycle.
  - Response: write lands, busy stays 0.
  - Stimulus: wr_en during a walk.
  - Response: memory unchanged, verified by read-back walk.
- Reset mid-walk:
  - Stimulus: assert rst while in OUT with out_valid=1.
  - Response: same cycle, asynchronously: out_valid=0, busy=0, zero=1, no done pulse.
  - Follow-up: a subsequent walk returns the pre-reset memory contents.
